pll_lock_supervisor: RTL and testbench

Supervisor for the board PLL: drives the PLL's reset input, watches its asynchronous lock output, and releases a clean, registered reset to the PLL-clocked logic only after lock has been held continuously for a programmable time. It runs on the always-present board oscillator clock, so it keeps working while the PLL output is absent. It re-resets the PLL after a lock timeout or a loss of lock, and keeps saturating event counters for debug display.

---
 rtl/pll_lock_supervisor.sv | 126 ++++++++++++
 tb/tb_pll_lock_supervisor.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: holds the PLL in reset, qualifies its lock on the board clock and
// releases a registered downstream reset only after lock has been stable long enough.
`timescale 1ns / 1ps

module pll_lock_supervisor #(
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned PLL_RST_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lock,
    output logic       pll_reset,
    output logic       rst_out,
    output logic       ready,
    output logic [7:0] loss_count,
    output logic [7:0] retry_count
);

    localparam int unsigned MaxA      = (STABLE_CYCLES > TIMEOUT_CYCLES) ?
                                        STABLE_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned MaxCycles = (MaxA > PLL_RST_CYCLES) ? MaxA : PLL_RST_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles);

    localparam logic [CntW-1:0] PllRstLast  = CntW'(PLL_RST_CYCLES - 1);
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0] StableLast  = CntW'(STABLE_CYCLES - 1);

    localparam logic [1:0] StPllRst   = 2'd0;
    localparam logic [1:0] StWaitLock = 2'd1;
    localparam logic [1:0] StStable   = 2'd2;
    localparam logic [1:0] StRun      = 2'd3;

    logic            sync1_q, lock_s_q;
    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      loss_q, loss_d;
    logic [7:0]      retry_q, retry_d;
    logic            pll_reset_q, pll_reset_d;
    logic            rst_out_q, rst_out_d;
    logic            ready_q, ready_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        loss_d  = loss_q;
        retry_d = retry_q;
        unique case (state_q)
            StPllRst: begin
                if (cnt_q == PllRstLast) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end
            end
            StWaitLock: begin
                // A lock arriving on the timeout cycle takes priority over a retry.
                if (lock_s_q) begin
                    state_d = StStable;
                    cnt_d   = '0;
                end else if (cnt_q == TimeoutLast) begin
                    state_d = StPllRst;
                    cnt_d   = '0;
                    retry_d = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
                end
            end
            StStable: begin
                if (!lock_s_q) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else if (cnt_q == StableLast) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                cnt_d = '0;
                if (!lock_s_q) begin
                    state_d = StPllRst;
                    loss_d  = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;
                end
            end
            default: begin
                state_d = StPllRst;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register on the same edge as state.
    always_comb begin
        pll_reset_d = (state_d == StPllRst);
        rst_out_d   = (state_d != StRun);
        ready_d     = (state_d == StRun);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            lock_s_q    <= 1'b0;
            state_q     <= StPllRst;
            cnt_q       <= '0;
            loss_q      <= 8'd0;
            retry_q     <= 8'd0;
            pll_reset_q <= 1'b1;
            rst_out_q   <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            sync1_q     <= lock;
            lock_s_q    <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            loss_q      <= loss_d;
            retry_q     <= retry_d;
            pll_reset_q <= pll_reset_d;
            rst_out_q   <= rst_out_d;
            ready_q     <= ready_d;
        end
    end

    assign pll_reset   = pll_reset_q;
    assign rst_out     = rst_out_q;
    assign ready       = ready_q;
    assign loss_count  = loss_q;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: edge-numbered scoreboard of expected output snapshots,
// a clean-start vector table and hand sequences for timeout, glitch, loss and saturation.
`timescale 1ns / 1ps

module tb_pll_lock_supervisor;

    localparam int unsigned SC = 8;
    localparam int unsigned TC = 64;
    localparam int unsigned PC = 4;
    localparam int          Period = TC + PC;  // one timeout/retry round, in edges

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lock = 1'b0;
    logic       pll_reset, rst_out, ready;
    logic [7:0] loss_count, retry_count;

    pll_lock_supervisor #(
        .STABLE_CYCLES (SC),
        .TIMEOUT_CYCLES(TC),
        .PLL_RST_CYCLES(PC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .lock       (lock),
        .pll_reset  (pll_reset),
        .rst_out    (rst_out),
        .ready      (ready),
        .loss_count (loss_count),
        .retry_count(retry_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pr;
        logic       ro;
        logic       rd;
        logic [7:0] lc;
        logic [7:0] rc;
    } exp_t;

    typedef struct {
        int    at_edge;
        string name;
        exp_t  e;
    } sb_t;

    typedef struct {
        logic lk;
        exp_t e;
    } vec_t;

    int  checks = 0;
    int  failures = 0;
    int  ecount = 0;
    sb_t sb_q[$];

    function automatic exp_t mk(logic pr, logic ro, logic rd, logic [7:0] lc, logic [7:0] rc);
        return {pr, ro, rd, lc, rc};
    endfunction

    function automatic exp_t dut_out();
        return {pll_reset, rst_out, ready, loss_count, retry_count};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", name, act, req, ecount);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event did not occur (edge %0d)", name, ecount);
    endtask

    task automatic expect_at(input int n, input string name, input exp_t e);
        sb_q.push_back('{n, name, e});
    endtask

    // Drive lock just after the current edge, advance one edge, then retire due expectations.
    task automatic tick(input logic l);
        sb_t s;
        lock = l;
        @(posedge clk);
        #1;
        ecount++;
        while (sb_q.size() > 0 && sb_q[0].at_edge <= ecount) begin
            s = sb_q.pop_front();
            if (s.at_edge < ecount) note_fail({s.name, " (skipped)"});
            else chk(s.name, 32'(dut_out()), 32'(s.e));
        end
    endtask

    task automatic apply_reset(input logic l);
        rst  = 1'b1;
        lock = l;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("reset_state", 32'(dut_out()), 32'(mk(1, 1, 0, 0, 0)));
        rst    = 1'b0;
        ecount = 0;
    endtask

    task automatic run_until_ready(input logic l, input int budget, output bit ok);
        ok = 1'b0;
        for (int j = 0; j < budget && !ok; j++) begin
            tick(l);
            ok = (ready === 1'b1);
        end
    endtask

    task automatic run_until_pll_reset(input logic l, input int budget, output bit ok);
        ok = 1'b0;
        for (int j = 0; j < budget && !ok; j++) begin
            tick(l);
            ok = (pll_reset === 1'b1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached (edge %0d)", ecount);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[15];
        bit   ok;
        int   n;

        for (int i = 0; i < 15; i++) begin
            int k;
            k         = i + 1;
            tbl[i].lk = 1'b1;
            if (k < int'(PC)) tbl[i].e = mk(1, 1, 0, 0, 0);
            else if (k < int'(PC + 1 + SC)) tbl[i].e = mk(0, 1, 0, 0, 0);
            else tbl[i].e = mk(0, 0, 1, 0, 0);
        end

        // Clean start with lock high throughout.
        apply_reset(1'b1);
        for (int i = 0; i < 15; i++) begin
            expect_at(ecount + 1, $sformatf("clean[%0d]", i + 1), tbl[i].e);
            tick(tbl[i].lk);
        end

        // Loss in RUN: lock falls after edge n.
        n = ecount;
        expect_at(n + 2, "loss_n2", mk(0, 0, 1, 0, 0));
        expect_at(n + 3, "loss_n3", mk(1, 1, 0, 1, 0));
        expect_at(n + 6, "loss_n6", mk(1, 1, 0, 1, 0));
        expect_at(n + 7, "loss_n7", mk(0, 1, 0, 1, 0));
        repeat (7) tick(1'b0);
        run_until_ready(1'b1, 40, ok);
        if (!ok) note_fail("relock_ready");

        // Asynchronous reset between edges while in RUN.
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", 32'(dut_out()), 32'(mk(1, 1, 0, 0, 0)));
        @(posedge clk);
        #1;
        rst    = 1'b0;
        ecount = 0;
        expect_at(12, "restart_stable_end", mk(0, 1, 0, 0, 0));
        expect_at(13, "restart_ready", mk(0, 0, 1, 0, 0));
        repeat (13) tick(1'b1);

        // Timeout and retry with lock held low, then lock rises after edge 200.
        apply_reset(1'b0);
        expect_at(67, "to_wait_last", mk(0, 1, 0, 0, 0));
        expect_at(68, "to_retry1", mk(1, 1, 0, 0, 1));
        expect_at(71, "to_rst_last", mk(1, 1, 0, 0, 1));
        expect_at(72, "to_wait2", mk(0, 1, 0, 0, 1));
        expect_at(135, "to_wait2_last", mk(0, 1, 0, 0, 1));
        expect_at(136, "to_retry2", mk(1, 1, 0, 0, 2));
        expect_at(140, "to_wait3", mk(0, 1, 0, 0, 2));
        repeat (200) tick(1'b0);
        expect_at(210, "to_lock_not_yet", mk(0, 1, 0, 0, 2));
        expect_at(211, "to_lock_ready", mk(0, 0, 1, 0, 2));
        repeat (11) tick(1'b1);

        // One-cycle lock glitch in STABLE restarts the full qualification.
        apply_reset(1'b1);
        expect_at(10, "glitch_stable", mk(0, 1, 0, 0, 0));
        expect_at(11, "glitch_wait", mk(0, 1, 0, 0, 0));
        expect_at(19, "glitch_stable_last", mk(0, 1, 0, 0, 0));
        expect_at(20, "glitch_ready", mk(0, 0, 1, 0, 0));
        for (int k = 1; k <= 20; k++) begin
            tick((k == 9) ? 1'b0 : 1'b1);
            if (k < 20) chk($sformatf("glitch_rst_out[%0d]", k), 32'(rst_out), 32'd1);
        end

        // Loss-count saturation.
        for (int i = 0; i < 260; i++) begin
            run_until_pll_reset(1'b0, 10, ok);
            if (!ok) begin
                note_fail($sformatf("sat_loss_drop[%0d]", i));
                break;
            end
            run_until_ready(1'b1, 40, ok);
            if (!ok) begin
                note_fail($sformatf("sat_loss_relock[%0d]", i));
                break;
            end
            if (i == 253) chk("sat_loss_254", 32'(loss_count), 32'd254);
            if (i == 254) chk("sat_loss_255", 32'(loss_count), 32'd255);
        end
        chk("sat_loss_hold", 32'(loss_count), 32'd255);
        chk("sat_loss_retry0", 32'(retry_count), 32'd0);

        // Retry-count saturation.
        apply_reset(1'b0);
        expect_at(Period * 254, "sat_retry_254", mk(1, 1, 0, 0, 254));
        expect_at(Period * 255, "sat_retry_255", mk(1, 1, 0, 0, 255));
        expect_at(Period * 260, "sat_retry_260", mk(1, 1, 0, 0, 255));
        expect_at(Period * 260 + int'(PC), "sat_retry_wait", mk(0, 1, 0, 0, 255));
        repeat (Period * 260 + 10) tick(1'b0);

        if (sb_q.size() != 0) note_fail($sformatf("scoreboard_drain (%0d left)", sb_q.size()));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
